// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (LSB first) computing a - b - bin with a registered borrow chain.
// Define SERIAL_ADDSUB_MODE_EN to add a 'mode' input selecting addition (mode=1) or subtraction.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef SERIAL_ADDSUB_MODE_EN
  input  logic         mode,
`endif
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   d_q, d_d;
  logic           br_q, br_d;
  logic           bout_q, bout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDSUB_MODE_EN
  logic           mode_q, mode_d;
`endif

  logic a0, b0, x_bit, br_next;

  always_comb begin
    a0    = a_sh_q[0];
    b0    = b_sh_q[0];
    x_bit = a0 ^ b0 ^ br_q;
`ifdef SERIAL_ADDSUB_MODE_EN
    if (mode_q) begin
      br_next = (a0 & b0) | (br_q & (a0 ^ b0));
    end else begin
      br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    end
`else
    br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_MODE_EN
    mode_d  = mode_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_MODE_EN
          mode_d  = mode;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        br_d          = br_next;
        res_d         = res_q >> 1;
        res_d[N-1]    = x_bit;
        a_sh_d        = a_sh_q >> 1;
        b_sh_d        = b_sh_q >> 1;
        cnt_d         = cnt_q + CW'(1);
        // Final bit: publish the completed word so d/bout stay stable through IDLE.
        if (cnt_q == CW'(N - 1)) begin
          d_d     = res_d;
          bout_d  = br_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, handshake corner cases and random ops.
module tb_serial_subtractor;
  localparam int N = 4;
  localparam int TMO = 3 * N + 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic [N-1:0] d;
  logic         bout, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDSUB_MODE_EN
    .mode  (mode),
`endif
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  // Reference: plain integer arithmetic on the whole operands.
  function automatic void ref_model(input int ta, input int tb_, input int tbin, input int tadd,
                                    output logic [N-1:0] ed, output logic eb);
    int r;
    if (tadd != 0) begin
      r  = ta + tb_ + tbin;
      eb = (r >= (1 << N));
    end else begin
      r  = ta - tb_ - tbin;
      eb = (r < 0);
    end
    r  = r & ((1 << N) - 1);
    ed = r[N-1:0];
  endfunction

  // Drives one operation and reports what the DUT showed; no checking here.
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tbin,
                        output logic [N-1:0] od, output logic ob, output int lat,
                        output logic busy_dn, output logic done_aft, output logic busy_aft);
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < TMO) begin
      @(negedge clk);
      lat++;
    end
    od = d; ob = bout; busy_dn = busy;
    @(negedge clk);
    done_aft = done; busy_aft = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({d, bout, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got d=%0d bout=%0b busy=%0b done=%0b, want all 0", d, bout, busy, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: got busy=%0b, want 0", busy);
    end
    $display("test_reset: d=%0d bout=%0b busy=%0b done=%0b", d, bout, busy, done);
  endtask

  task automatic test_directed();
    logic [N-1:0] ta [4] = '{4'd9, 4'd5, 4'd0, 4'd15};
    logic [N-1:0] tbv[4] = '{4'd5, 4'd9, 4'd0, 4'd15};
    logic         tbi[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] wd [4] = '{4'b0100, 4'b1100, 4'b1111, 4'b0000};
    logic         wb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] od; logic ob, bdn, dafter, bafter; int lat;
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tbv[i], tbi[i], od, ob, lat, bdn, dafter, bafter);
      $display("test_directed: a=%0d b=%0d bin=%0b -> d=%0d bout=%0b lat=%0d", ta[i], tbv[i], tbi[i], od, ob, lat);
      n_cmp++;
      if (od !== wd[i] || ob !== wb[i]) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got d=%0d bout=%0b, want d=%0d bout=%0b", i, od, ob, wd[i], wb[i]);
      end
      n_cmp++;
      if (lat !== N) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, N);
      end
      n_cmp++;
      if (bdn !== 1'b1 || dafter !== 1'b0 || bafter !== 1'b0) begin
        n_bad++;
        $display("FAIL directed_handshake[%0d]: busy_in_done=%0b done_after=%0b busy_after=%0b, want 1 0 0", i, bdn, dafter, bafter);
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [N-1:0] seen_d = '0;
    logic seen_b = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    a = 4'd3; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd8; b = 4'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      if (done) begin
        pulses++;
        seen_d = d; seen_b = bout;
      end
      @(negedge clk);
    end
    $display("test_ignore_start: pulses=%0d d=%0d bout=%0b", pulses, seen_d, seen_b);
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
    end
    n_cmp++;
    if (seen_d !== 4'd2 || seen_b !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_result: got d=%0d bout=%0b, want d=2 bout=0", seen_d, seen_b);
    end
  endtask

  task automatic test_midrun_reset();
    logic [N-1:0] od; logic ob, bdn, dafter, bafter; int lat;
    mode = 1'b0;
    @(negedge clk);
    a = 4'd12; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("test_midrun_reset: during reset d=%0d bout=%0b busy=%0b done=%0b", d, bout, busy, done);
    n_cmp++;
    if ({d, bout, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got d=%0d bout=%0b busy=%0b done=%0b, want all 0", d, bout, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_idle: got busy=%0b, want 0", busy);
    end
    run_op(4'd12, 4'd3, 1'b0, od, ob, lat, bdn, dafter, bafter);
    $display("test_midrun_reset: rerun d=%0d bout=%0b lat=%0d", od, ob, lat);
    n_cmp++;
    if (od !== 4'd9 || ob !== 1'b0 || lat !== N) begin
      n_bad++;
      $display("FAIL midrun_rerun: got d=%0d bout=%0b lat=%0d, want d=9 bout=0 lat=%0d", od, ob, lat, N);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a1, b1, a2, b2, ed, d1, d2;
    logic eb, bo1, bo2;
    int lat1 = 0, gap = 0;
    mode = 1'b0;
    a1 = N'($urandom); b1 = N'($urandom);
    a2 = N'($urandom); b2 = N'($urandom);
    @(negedge clk);
    a = a1; b = b1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    while (!done && lat1 < TMO) begin
      @(negedge clk);
      lat1++;
    end
    d1 = d; bo1 = bout;
    a = a2; b = b2;
    @(negedge clk);
    gap = 1;
    while (!done && gap < TMO) begin
      @(negedge clk);
      gap++;
    end
    d2 = d; bo2 = bout;
    start = 1'b0;
    $display("test_back_to_back: op1 %0d-%0d=%0d/%0b lat=%0d op2 %0d-%0d=%0d/%0b gap=%0d",
             a1, b1, d1, bo1, lat1, a2, b2, d2, bo2, gap);
    ref_model(int'(a1), int'(b1), 0, 0, ed, eb);
    n_cmp++;
    if (d1 !== ed || bo1 !== eb || lat1 !== N) begin
      n_bad++;
      $display("FAIL b2b_first: got d=%0d bout=%0b lat=%0d, want d=%0d bout=%0b lat=%0d", d1, bo1, lat1, ed, eb, N);
    end
    ref_model(int'(a2), int'(b2), 0, 0, ed, eb);
    n_cmp++;
    if (d2 !== ed || bo2 !== eb || gap !== N + 2) begin
      n_bad++;
      $display("FAIL b2b_second: got d=%0d bout=%0b gap=%0d, want d=%0d bout=%0b gap=%0d", d2, bo2, gap, ed, eb, N + 2);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_release: got busy=%0b, want 0", busy);
    end
  endtask

  task automatic test_mode();
`ifdef SERIAL_ADDSUB_MODE_EN
    logic [N-1:0] od; logic ob, bdn, dafter, bafter; int lat;
    mode = 1'b1;
    run_op(4'd7, 4'd9, 1'b0, od, ob, lat, bdn, dafter, bafter);
    $display("test_mode: add 7+9 -> d=%0d bout=%0b", od, ob);
    n_cmp++;
    if (od !== 4'b0000 || ob !== 1'b1) begin
      n_bad++;
      $display("FAIL mode_add: got d=%0d bout=%0b, want d=0 bout=1", od, ob);
    end
    mode = 1'b0;
    run_op(4'd7, 4'd9, 1'b0, od, ob, lat, bdn, dafter, bafter);
    $display("test_mode: sub 7-9 -> d=%0d bout=%0b", od, ob);
    n_cmp++;
    if (od !== 4'b1110 || ob !== 1'b1) begin
      n_bad++;
      $display("FAIL mode_sub: got d=%0d bout=%0b, want d=14 bout=1", od, ob);
    end
`endif
  endtask

  task automatic test_random();
    logic [N-1:0] ta, tbv, od, ed; logic tbi, ob, eb, bdn, dafter, bafter; int lat, tadd;
    for (int i = 0; i < 25; i++) begin
      ta = N'($urandom); tbv = N'($urandom); tbi = 1'($urandom);
`ifdef SERIAL_ADDSUB_MODE_EN
      tadd = int'($urandom_range(0, 1));
`else
      tadd = 0;
`endif
      mode = (tadd != 0);
      run_op(ta, tbv, tbi, od, ob, lat, bdn, dafter, bafter);
      ref_model(int'(ta), int'(tbv), int'(tbi), tadd, ed, eb);
      $display("test_random[%0d]: a=%0d b=%0d bin=%0b add=%0d -> d=%0d bout=%0b lat=%0d", i, ta, tbv, tbi, tadd, od, ob, lat);
      n_cmp++;
      if (od !== ed || ob !== eb || lat !== N) begin
        n_bad++;
        $display("FAIL random[%0d]: got d=%0d bout=%0b lat=%0d, want d=%0d bout=%0b lat=%0d", i, od, ob, lat, ed, eb, N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_midrun_reset();
    test_back_to_back();
    test_mode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, LSB first, one bit per clock. Each bit uses the full-subtractor equations; a registered borrow links consecutive bits.
- Counterpart to the dataflow full adder. It undoes the adder's operation in sequential form and is the building block for later serial ALU and divider work.
- Operands are loaded in parallel on a start handshake. Difference and borrow-out are presented in parallel with a one-cycle done pulse.

Parameters:
- N, 4, operand and result width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin; sampled only in IDLE
- a  input  N  minuend, captured on accepted start
- b  input  N  subtrahend, captured on accepted start
- bin  input  1  borrow-in, captured on accepted start
- d  output  N  difference a - b - bin, mod 2^N
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned)
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset: asynchronous on rst_n low, effective immediately, including mid-operation.
  - State goes to IDLE.
  - d, bout, busy, done and all internal registers clear to 0; bit counter clears to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0; d and bout hold the last result.
  - start=1 at a rising edge is accepted. On acceptance: a_sh<=a, b_sh<=b, br<=bin, cnt<=0, state<=RUN.
- RUN, on each edge:
  - x = a_sh[0] ^ b_sh[0] ^ br
  - br <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - Result shift register shifts right with x inserted at bit N-1.
  - a_sh and b_sh shift right by 1; cnt increments.
  - When cnt == N-1 at the edge, state <= DONE. RUN therefore lasts exactly N cycles.
- DONE (one cycle):
  - d = assembled result; bout = br; done=1; busy=1.
  - Next edge: state <= IDLE.
- Latency: start sampled at edge 0, done high in the cycle after edge N, valid d/bout from that cycle onward. Throughput is one operation per N+2 cycles.
- Boundaries:
  - start while busy (RUN or DONE) is ignored; there is no queueing.
  - start held high continuously is accepted again on the first IDLE edge.
  - a or b changing after acceptance has no effect.
  - N=1 gives one RUN cycle.
  - cnt is sized clog2(N+1) bits and never wraps.
- Arithmetic: unsigned mod 2^N; d equals (a - b - bin) mod 2^N.

Optional Feature:
- Macro: SERIAL_ADDSUB_MODE_EN.
- Defined:
  - Extra input port mode (1 bit), captured on accepted start alongside a and b.
  - mode=1 selects addition: x = a^b^c, c_next = a&b | c&(a^b). bin acts as carry-in; bout reports carry-out.
  - mode=0 behaves exactly as subtraction.
- Undefined: no mode port; the block always subtracts.
- Timing, handshake and reset are identical in both builds.

Test Plan:
- N=4, a=9, b=5, bin=0, pulse start -> done at cycle 5 after start edge, d=4'b0100, bout=0, busy low the following cycle.
- N=4, a=5, b=9, bin=0 -> d=4'b1100, bout=1.
- N=4, a=0, b=0, bin=1 -> d=4'b1111, bout=1. Then a=15, b=15, bin=0 -> d=0, bout=0.
- Start pulsed with a=3,b=1, then at cycle 2 start with a=8,b=8 -> second start ignored, d=2, bout=0, exactly one done pulse.
- rst_n low during cycle 3 of RUN (a=12,b=3) -> d, bout, busy, done immediately 0, state IDLE. Subsequent a=12,b=3 op -> d=9, bout=0.
- With SERIAL_ADDSUB_MODE_EN, mode=1, a=7, b=9, bin=0 -> d=4'b0000, bout=1. With mode=0, same operands -> d=4'b1110, bout=1.
